prog_mem_loader: RTL

Parametrised program memory for the RISC-V core with an integrated byte-stream boot loader. Replaces the single-size, combinational-read instruction store with a synchronous-read fetch port plus a handshaked load port. The load port assembles little-endian bytes (from the UART or debug path) into 32-bit words and writes them sequentially from word 0. Fetch is blocked while a load is in progress, and the core is stalled through `busy_o`.

---
 rtl/prog_mem_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/prog_mem_loader.sv
// Program memory with a synchronous-read fetch port and a byte-stream boot loader.
// Little-endian bytes are packed into 32-bit words and written sequentially from word 0.
module prog_mem_loader #(
    parameter int          DEPTH     = 4096,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req_i,
    input  logic [31:0]   fetch_addr_i,
    output logic [31:0]   fetch_data_o,
    output logic          fetch_valid_o,
    output logic          fetch_err_o,
    input  logic          load_start_i,
    input  logic [AW:0]   load_len_i,
    input  logic [7:0]    load_byte_i,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    output logic          busy_o,
    output logic          load_done_o
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_LOAD   = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [32:0] LP_SPAN  = 33'(DEPTH) << 2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [AW:0]   r_words_left;
    logic [AW-1:0] r_wr_ptr;
    logic [1:0]    r_byte_cnt;

    logic          w_start;
    logic          w_accept;
    logic          w_word_wr;
    logic          w_last_word;
    logic [AW:0]   w_len_clamped;
    logic [31:0]   w_word;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rdata;
    logic          r_fetch_valid;
    logic          r_fetch_err;
    logic [31:0]   w_offset;
    logic [AW-1:0] w_rd_addr;
    logic          w_fetch_take;
    logic          w_fetch_err;

    assign w_start       = (r_state == S_IDLE) && load_start_i;
    assign w_accept      = (r_state == S_LOAD) && load_valid_i;
    assign w_word_wr     = w_accept && (r_byte_cnt == 2'd3);
    assign w_last_word   = w_word_wr && (r_words_left == (AW+1)'(1));
    assign w_len_clamped = (load_len_i > LP_DEPTH) ? LP_DEPTH : load_len_i;

    // Lanes 0..2 hold the partial word; lane 3 is the incoming byte itself.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] r_lane;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lane <= 8'h00;
            end else if (w_accept && (r_byte_cnt == 2'(gi))) begin
                r_lane <= load_byte_i;
            end
        end
    end

    assign w_word = {load_byte_i, g_lane[2].r_lane, g_lane[1].r_lane, g_lane[0].r_lane};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start_i) begin
                    w_state_next = (load_len_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last_word) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The pointer stops on the final word so it never wraps past DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_byte_cnt   <= 2'd0;
            r_words_left <= '0;
        end else if (w_start) begin
            r_wr_ptr     <= '0;
            r_byte_cnt   <= 2'd0;
            r_words_left <= w_len_clamped;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_word_wr) begin
                r_words_left <= r_words_left - (AW+1)'(1);
                if (!w_last_word) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
            end
        end
    end

    assign w_offset     = fetch_addr_i - BASE_ADDR;
    assign w_rd_addr    = w_offset[AW+1:2];
    assign w_fetch_take = fetch_req_i && (r_state != S_LOAD);
    assign w_fetch_err  = (fetch_addr_i[1:0] != 2'b00) || ({1'b0, w_offset} >= LP_SPAN);

    // No reset on the array or read register so the store maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_word_wr) begin
            r_mem[r_wr_ptr] <= w_word;
        end
        if (w_fetch_take) begin
            r_rdata <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_take;
            r_fetch_err   <= w_fetch_take && w_fetch_err;
        end
    end

    assign fetch_valid_o = r_fetch_valid;
    assign fetch_err_o   = r_fetch_err;
    assign fetch_data_o  = (r_fetch_valid && !r_fetch_err) ? r_rdata : 32'h0000_0000;
    assign load_ready_o  = (r_state == S_LOAD);
    assign busy_o        = (r_state == S_LOAD);
    assign load_done_o   = (r_state == S_DONE);

endmodule
